// File: rtl/pipeline_sched_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
package pipeline_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        DRAIN     = 2'd2,
        REDIRECT  = 2'd3
    } sched_state_t;

    // Default performance-counter width.
    localparam int unsigned SCHED_CNT_W  = 32;
    // Default number of per-stage ok_to_proceed votes (IF, ID, EX, MEM, WB).
    localparam int unsigned SCHED_NSTAGE = 5;
    // Architectural register-number width and address width.
    localparam int unsigned SCHED_REG_W  = 5;
    localparam int unsigned SCHED_XLEN   = 64;

    // True when a source operand is actually read and names the given register.
    function automatic logic src_match(
        input logic                   use_src,
        input logic [SCHED_REG_W-1:0] src,
        input logic [SCHED_REG_W-1:0] wd
    );
        return use_src && (src == wd);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load still sitting in EX. x0 never creates a hazard.
module hazard_cmp
    import pipeline_sched_pkg::*;
(
    input  logic                   i_id_valid,
    input  logic [SCHED_REG_W-1:0] i_id_rs1,
    input  logic [SCHED_REG_W-1:0] i_id_rs2,
    input  logic                   i_id_use_rs1,
    input  logic                   i_id_use_rs2,
    input  logic                   i_ex_load_valid,
    input  logic [SCHED_REG_W-1:0] i_ex_load_wd,
    output logic                   o_lu_hit
);

    logic w_wd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // Compare both sources against the in-flight load destination.
    always_comb begin
        w_wd_nonzero = (i_ex_load_wd != '0);
        w_rs1_hit    = src_match(i_id_use_rs1, i_id_rs1, i_ex_load_wd);
        w_rs2_hit    = src_match(i_id_use_rs2, i_id_rs2, i_ex_load_wd);
        o_lu_hit     = i_id_valid && i_ex_load_valid && w_wd_nonzero
                       && (w_rs1_hit || w_rs2_hit);
    end

endmodule

// File: rtl/pipeline_sched.sv
// Central stall/flush scheduler: global advance enable, load-use bubbles,
// jump flushes, trap drain/redirect and wrap-around performance counters.
module pipeline_sched
    import pipeline_sched_pkg::*;
#(
    parameter int unsigned NSTAGE = SCHED_NSTAGE,
    parameter int unsigned CNT_W  = SCHED_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSTAGE-1:0]      stage_ok,
    input  logic                   id_valid,
    input  logic [SCHED_REG_W-1:0] id_rs1,
    input  logic [SCHED_REG_W-1:0] id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   ex_load_valid,
    input  logic [SCHED_REG_W-1:0] ex_load_wd,
    input  logic                   jump_en,
    input  logic                   trap_req,
    input  logic [SCHED_XLEN-1:0]  trap_vec,
    input  logic                   mem_busy,
    output logic                   ok_to_proceed_overall,
    output logic                   hold_if_id,
    output logic                   bubble_id_ex,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   redirect_valid,
    output logic [SCHED_XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic [SCHED_XLEN-1:0] r_vec;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_bubble_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic w_lu_hit;
    logic w_all_ok;
    logic w_adv;
    logic w_ok;
    logic w_hold;
    logic w_bubble;
    logic w_flush_if;
    logic w_flush_ex;
    logic w_redirect;
    logic w_latch_vec;

    hazard_cmp u_hazard_cmp (
        .i_id_valid      (id_valid),
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_use_rs1    (id_use_rs1),
        .i_id_use_rs2    (id_use_rs2),
        .i_ex_load_valid (ex_load_valid),
        .i_ex_load_wd    (ex_load_wd),
        .o_lu_hit        (w_lu_hit)
    );

    assign w_all_ok = &stage_ok;

    // Next-state and decode outputs; everything is zero-latency from state and inputs.
    always_comb begin
        w_state_next = r_state;
        w_adv        = w_all_ok;
        w_ok         = w_all_ok;
        w_hold       = 1'b0;
        w_bubble     = 1'b0;
        w_flush_if   = 1'b0;
        w_flush_ex   = 1'b0;
        w_redirect   = 1'b0;
        w_latch_vec  = 1'b0;

        case (r_state)
            RUN: begin
                // Trap beats jump: no jump flush in the trap cycle.
                if (trap_req) begin
                    w_state_next = DRAIN;
                    w_latch_vec  = 1'b1;
                end else if (jump_en) begin
                    w_flush_if = 1'b1;
                    w_flush_ex = 1'b1;
                end else if (w_lu_hit && w_adv) begin
                    w_state_next = LU_BUBBLE;
                end
            end
            LU_BUBBLE: begin
                w_hold   = 1'b1;
                w_bubble = 1'b1;
                if (trap_req) begin
                    w_state_next = DRAIN;
                    w_latch_vec  = 1'b1;
                end else if (jump_en) begin
                    // The stalled ID instruction is on the wrong path; flush it instead.
                    w_hold       = 1'b0;
                    w_bubble     = 1'b0;
                    w_flush_if   = 1'b1;
                    w_flush_ex   = 1'b1;
                    w_state_next = RUN;
                end else if (w_adv) begin
                    w_state_next = RUN;
                end
            end
            DRAIN: begin
                // Freeze the pipe until outstanding memory traffic completes.
                w_adv      = 1'b0;
                w_ok       = 1'b0;
                w_flush_if = 1'b1;
                w_flush_ex = 1'b1;
                if (!mem_busy) begin
                    w_state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                w_ok         = 1'b1;
                w_redirect   = 1'b1;
                w_flush_if   = 1'b1;
                w_flush_ex   = 1'b1;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // State register; reset discards any pending redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Trap vector capture, taken only in the cycle the trap is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec <= '0;
        end else if (w_latch_vec) begin
            r_vec <= trap_vec;
        end
    end

    // Wrap-around performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!w_ok) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_bubble && w_ok) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
            if (w_flush_ex) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign ok_to_proceed_overall = w_ok;
    assign hold_if_id            = w_hold;
    assign bubble_id_ex          = w_bubble;
    assign flush_if_id           = w_flush_if;
    assign flush_id_ex           = w_flush_ex;
    assign redirect_valid        = w_redirect;
    assign redirect_pc           = r_vec;
    assign stall_cnt             = r_stall_cnt;
    assign bubble_cnt            = r_bubble_cnt;
    assign flush_cnt             = r_flush_cnt;

endmodule
